// File: rtl/tow_press_gen.sv
// Tug-of-war player input: per-button 2-flop sync, debounce FSM with reset lockout, tie/freeze arbiter.
// Define TOW_PRESS_COUNT_EN to add saturating per-player pulse counters press_cnt_l/press_cnt_r.
module tow_press_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l,
  input  logic       key_r,
  input  logic       freeze,
`ifdef TOW_PRESS_COUNT_EN
  output logic [7:0] press_cnt_l,
  output logic [7:0] press_cnt_r,
`endif
  output logic       L,
  output logic       R
);

  localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    ST_LOCKOUT = 2'd0;
  localparam logic [1:0]    ST_IDLE    = 2'd1;
  localparam logic [1:0]    ST_DOWN    = 2'd2;

  logic [1:0]         pressed;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         ev;
  logic [1:0]         ev_next;
  logic [1:0][1:0]    state;
  logic [1:0][1:0]    state_next;
  logic [1:0][CW-1:0] cnt;
  logic [1:0][CW-1:0] cnt_next;
  logic               l_next;
  logic               r_next;

  // Bit 0 is the left player, bit 1 the right player; 1 means pressed.
  assign pressed = {key_r, key_l} ^ {2{KEY_ACTIVE_LOW}};

  // Debounce: count stable samples of the target level; IDLE wants pressed, others want released.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ev_next    = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2[ch] == (state[ch] == ST_IDLE)) begin
        if (cnt[ch] == CNT_LAST) begin
          cnt_next[ch] = {CW{1'b0}};
          case (state[ch])
            ST_LOCKOUT: state_next[ch] = ST_IDLE;
            ST_IDLE: begin
              state_next[ch] = ST_DOWN;
              ev_next[ch]    = 1'b1;
            end
            ST_DOWN: state_next[ch] = ST_IDLE;
            default: state_next[ch] = ST_LOCKOUT;
          endcase
        end else begin
          cnt_next[ch] = cnt[ch] + CW'(1);
        end
      end else begin
        cnt_next[ch] = {CW{1'b0}};
      end
    end
  end

  // Arbiter: a simultaneous pair cancels, and freeze swallows both.
  always_comb begin
    l_next = 1'b0;
    r_next = 1'b0;
    if (!freeze) begin
      l_next = ev[0] & ~ev[1];
      r_next = ev[1] & ~ev[0];
    end else begin
      l_next = 1'b0;
      r_next = 1'b0;
    end
  end

  // Synchroniser, debounce state, press events and registered move pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      state <= {ST_LOCKOUT, ST_LOCKOUT};
      cnt   <= {(2 * CW){1'b0}};
      ev    <= 2'b00;
      L     <= 1'b0;
      R     <= 1'b0;
    end else begin
      sync1 <= pressed;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
      ev    <= ev_next;
      L     <= l_next;
      R     <= r_next;
    end
  end

`ifdef TOW_PRESS_COUNT_EN
  // Count emitted pulses only, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_cnt_l <= 8'd0;
      press_cnt_r <= 8'd0;
    end else begin
      if (l_next && (press_cnt_l != 8'd255)) begin
        press_cnt_l <= press_cnt_l + 8'd1;
      end
      if (r_next && (press_cnt_r != 8'd255)) begin
        press_cnt_r <= press_cnt_r + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tow_press_gen.sv
// Bench for tow_press_gen: directed scenarios plus random key activity, every cycle compared
// against a history-based reference model. Checks press counters when TOW_PRESS_COUNT_EN is set.
module tb_tow_press_gen;

  localparam int D    = 4;
  localparam int HMAX = 16384;

  logic clk = 1'b0;
  logic reset;
  logic key_l;
  logic key_r;
  logic freeze;
  logic L;
  logic R;
`ifdef TOW_PRESS_COUNT_EN
  logic [7:0] press_cnt_l;
  logic [7:0] press_cnt_r;
  logic [7:0] m_cnt_l;
  logic [7:0] m_cnt_r;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model: raw pressed history since reset, accepted-change bookkeeping.
  bit       pr [0:1][0:HMAX-1];
  int       n;
  int       last_acc [0:1];
  bit [1:0] armed;
  bit [1:0] lvl;
  bit [1:0] ev_m;
  bit       exp_l;
  bit       exp_r;

  int tk, l_pulses, r_pulses, l_at, r_at;

  tow_press_gen #(
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_l      (key_l),
    .key_r      (key_r),
    .freeze     (freeze),
`ifdef TOW_PRESS_COUNT_EN
    .press_cnt_l(press_cnt_l),
    .press_cnt_r(press_cnt_r),
`endif
    .L          (L),
    .R          (R)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Synchronised level seen by the debouncer at edge k is the raw level sampled two edges earlier.
  function automatic bit s2_at(int ch, int k);
    return (k >= 2) ? pr[ch][k-2] : 1'b0;
  endfunction

  task automatic model_reset();
    n        = 0;
    last_acc = '{-1, -1};
    armed    = 2'b00;
    lvl      = 2'b00;
    ev_m     = 2'b00;
    exp_l    = 1'b0;
    exp_r    = 1'b0;
`ifdef TOW_PRESS_COUNT_EN
    m_cnt_l = 8'd0;
    m_cnt_r = 8'd0;
`endif
  endtask

  task automatic model_step();
    bit       want;
    bit       ok;
    bit [1:0] nev;
    if (n >= HMAX) begin
      $display("FAIL model_history: overflow at %0d", n);
      $fatal(1);
    end
    exp_l = ev_m[0] & ~ev_m[1] & ~freeze;
    exp_r = ev_m[1] & ~ev_m[0] & ~freeze;
`ifdef TOW_PRESS_COUNT_EN
    if (exp_l && m_cnt_l != 8'd255) m_cnt_l = m_cnt_l + 8'd1;
    if (exp_r && m_cnt_r != 8'd255) m_cnt_r = m_cnt_r + 8'd1;
`endif
    pr[0][n] = ~key_l;
    pr[1][n] = ~key_r;
    nev = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      want = armed[ch] ? ~lvl[ch] : 1'b0;
      if (n - last_acc[ch] >= D) begin
        ok = 1'b1;
        for (int j = n - D + 1; j <= n; j++) begin
          if (s2_at(ch, j) != want) ok = 1'b0;
        end
        if (ok) begin
          last_acc[ch] = n;
          if (!armed[ch]) armed[ch] = 1'b1;
          else if (!lvl[ch]) begin
            lvl[ch] = 1'b1;
            nev[ch] = 1'b1;
          end else lvl[ch] = 1'b0;
        end
      end
    end
    ev_m = nev;
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clk);
    check("L", 16'(L), 16'(exp_l));
    check("R", 16'(R), 16'(exp_r));
    check("LR_exclusive", 16'(L & R), 16'd0);
`ifdef TOW_PRESS_COUNT_EN
    check("press_cnt_l", 16'(press_cnt_l), 16'(m_cnt_l));
    check("press_cnt_r", 16'(press_cnt_r), 16'(m_cnt_r));
`endif
    if (L === 1'b1) begin l_pulses++; l_at = tk; end
    if (R === 1'b1) begin r_pulses++; r_at = tk; end
    tk++;
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic clr_pulses();
    l_pulses = 0; r_pulses = 0; l_at = -1; r_at = -1;
  endtask

  initial begin
    int t0;
    tk = 0;
    clr_pulses();
    model_reset();
    reset = 1'b0; key_l = 1'b1; key_r = 1'b1; freeze = 1'b0;
    hold(2);
    reset = 1'b1;
    hold(10);

    // Clean left press held 20 cycles.
    clr_pulses(); t0 = tk; key_l = 1'b0;
    hold(20);
    check("clean_l_count", 16'(l_pulses), 16'd1);
    check("clean_l_latency", 16'(l_at - t0), 16'd6);
    check("clean_r_count", 16'(r_pulses), 16'd0);
    key_l = 1'b1; hold(10);

    // Right bounce, then stable press.
    clr_pulses();
    for (int b = 0; b < 4; b++) begin
      key_r = b[0]; hold(2);
    end
    check("bounce_r_none", 16'(r_pulses), 16'd0);
    t0 = tk; key_r = 1'b0; hold(12);
    check("bounce_r_count", 16'(r_pulses), 16'd1);
    check("bounce_r_latency", 16'(r_at - t0), 16'd6);
    key_r = 1'b1; hold(10);

    // Simultaneous press cancels, later left press still works.
    clr_pulses(); key_l = 1'b0; key_r = 1'b0; hold(15);
    check("tie_l", 16'(l_pulses), 16'd0);
    check("tie_r", 16'(r_pulses), 16'd0);
    key_l = 1'b1; key_r = 1'b1; hold(10);
    key_l = 1'b0; hold(12);
    check("after_tie_l", 16'(l_pulses), 16'd1);
    key_l = 1'b1; hold(10);

    // Freeze swallows a press and it never replays.
    clr_pulses(); freeze = 1'b1; key_l = 1'b0; hold(12);
    key_l = 1'b1; hold(10);
    freeze = 1'b0; hold(3);
    check("freeze_none", 16'(l_pulses), 16'd0);
    t0 = tk; key_l = 1'b0; hold(12);
    check("unfreeze_count", 16'(l_pulses), 16'd1);
    check("unfreeze_latency", 16'(l_at - t0), 16'd6);
    key_l = 1'b1; hold(10);

    // Right key held through reset must not pulse until released and re-pressed.
    key_r = 1'b0; hold(3);
    reset = 1'b0; hold(2);
    reset = 1'b1; clr_pulses(); hold(30);
    check("held_reset_none", 16'(r_pulses), 16'd0);
    key_r = 1'b1; hold(5);
    key_r = 1'b0; hold(12);
    check("held_reset_repress", 16'(r_pulses), 16'd1);
    key_r = 1'b1; hold(10);

    // Reset during a pulse drops L at once.
    clr_pulses(); key_l = 1'b0; hold(7);
    check("pre_reset_pulse", 16'(l_pulses), 16'd1);
    check("pre_reset_L_high", 16'(L), 16'd1);
    reset = 1'b0; #1;
    check("async_reset_L", 16'(L), 16'd0);
    key_l = 1'b1; hold(2);
    reset = 1'b1; hold(10);

    // Random key activity against the model.
    for (int s = 0; s < 80; s++) begin
      key_l  = 1'($urandom_range(0, 1));
      key_r  = 1'($urandom_range(0, 1));
      freeze = ($urandom_range(0, 7) == 0);
      hold($urandom_range(1, 10));
    end
    key_l = 1'b1; key_r = 1'b1; freeze = 1'b0; hold(10);

`ifdef TOW_PRESS_COUNT_EN
    // Counter saturation.
    for (int p = 0; p < 300; p++) begin
      key_l = 1'b0; hold(7);
      key_l = 1'b1; hold(7);
    end
    check("cnt_l_saturated", 16'(press_cnt_l), 16'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tow_press_gen.md
Name: tow_press_gen

Overview:
Player-input front end for the tug-of-war game. It turns two raw, bouncy push-button inputs into the clean single-cycle L and R move pulses consumed by the LED chain. Each button passes through a 2-flop synchroniser, a per-button debounce FSM, and a shared arbiter that cancels simultaneous presses and honours a game-over freeze.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change; legal range 1..65535.
KEY_ACTIVE_LOW, 1, 1 = key_l/key_r read 0 when pressed (board KEYs); 0 = pressed reads 1.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
key_l  input  1  raw left-player button, asynchronous to clk
key_r  input  1  raw right-player button, asynchronous to clk
freeze  input  1  synchronous; 1 = game over, discard accepted presses
L  output  1  registered; one-cycle pulse per accepted left press
R  output  1  registered; one-cycle pulse per accepted right press

Behaviour:
- Reset (reset=0, async): sync flops to "released"; debounce counters 0; both FSMs to LOCKOUT; L=R=0. Any press in progress is abandoned.
- Polarity: pressed = key ^ KEY_ACTIVE_LOW, applied before the synchroniser. Only the 2nd sync flop (s2) is used downstream.
- Per-channel FSM states: LOCKOUT, IDLE (released), DOWN (pressed).
- Counter cnt, width clog2(DEBOUNCE_CYCLES+1):
  - Target level: pressed in IDLE; released in LOCKOUT and DOWN.
  - s2 equal to target: cnt+1. Otherwise: cnt=0.
  - Transition fires on the edge where cnt would reach DEBOUNCE_CYCLES; cnt then clears.
- Transitions: LOCKOUT->IDLE on stable release; IDLE->DOWN on stable press, raising an internal press event for that edge; DOWN->IDLE on stable release (no event). A button held through reset therefore never pulses until released and re-pressed.
- Latency: raw press stable before edge 0 -> s2=1 after edge 1 -> FSM enters DOWN at edge DEBOUNCE_CYCLES+1 -> L/R high after edge DEBOUNCE_CYCLES+2, low after the next edge. Exactly one pulse per accepted press, independent of hold time.
- Bounce: any s2 glitch shorter than DEBOUNCE_CYCLES clears cnt; no transition, no event.
- Arbiter, combinational on this cycle's events, registered into L/R:
  - Left event only -> L=1.
  - Right event only -> R=1.
  - Both events in the same cycle -> L=R=0; both presses are consumed and lost (tie cancels).
  - freeze=1 -> L=R=0. FSMs keep tracking, so a press accepted during freeze never replays after freeze drops.
- Invariant: L and R are never 1 in the same cycle.
- Reset asserted mid-debounce or mid-pulse: outputs drop to 0 asynchronously; no pulse after deassertion until LOCKOUT clears.

Optional Feature:
TOW_PRESS_COUNT_EN
- Defined: adds outputs press_cnt_l[7:0] and press_cnt_r[7:0].
  - Each increments on every emitted L or R pulse and saturates at 255.
  - Cancelled ties and frozen presses are not counted.
  - Both clear on reset.
- Undefined: these ports and their counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1; reset released with key_l=1; drive key_l=0 at edge 0, hold 20 cycles -> L=1 only between edges 6 and 7; R=0 throughout.
- key_r bounces 0,1,0,1 each for 2 cycles, then holds 0 -> no pulse during bounce; single R pulse 6 edges after the final 0 begins.
- key_l and key_r both driven to 0 at the same edge, held -> L=R=0 for all cycles; after both release and key_l is re-pressed -> one L pulse.
- freeze=1, press key_l -> no L pulse. Release, drop freeze, press key_l again -> one L pulse at the normal latency.
- Hold key_r=0 through reset, deassert reset, keep holding 30 cycles -> no R pulse. Release for 5 cycles, press again -> one R pulse.
- TOW_PRESS_COUNT_EN defined: 3 left presses, 1 tie, 2 right presses -> press_cnt_l=3, press_cnt_r=2; 300 left presses -> press_cnt_l=255.
